// File: rtl/riscv_ifetch_queue.sv
// rtl/riscv_ifetch_queue.sv - DEPTH-entry {pc, instr} fetch queue with PC check, flush and counters
module riscv_ifetch_queue #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [ILEN-1:0]          in_instr,
    input  logic                     fetch_req,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic                     flush,
    output logic                     rsp_valid,
    output logic [ILEN-1:0]          rsp_instr,
    output logic                     rsp_err,
    output logic [3:0]               rsp_opclass,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         mismatch_cnt
);

    localparam int AW = $clog2(DEPTH);

    // NOP (addi x0, x0, 0) sized to the instruction width
    localparam logic [ILEN-1:0] NOP_INSTR   = ILEN'(32'h0000_0013);
    localparam logic [3:0]      OPC_ITYPE   = 4'd7;
    localparam logic [AW:0]     DEPTH_COUNT = (AW+1)'(DEPTH);

    // Opcode class of a RISC-V base instruction; unknown opcodes map to 15
    function automatic logic [3:0] decode_opclass(input logic [6:0] opcode);
        logic [3:0] cls;
        case (opcode)
            7'b0110111: cls = 4'd0;   // LUI
            7'b0010111: cls = 4'd1;   // AUIPC
            7'b1101111: cls = 4'd2;   // JAL
            7'b1100111: cls = 4'd3;   // JALR
            7'b1100011: cls = 4'd4;   // BRANCH
            7'b0000011: cls = 4'd5;   // LOAD
            7'b0100011: cls = 4'd6;   // STORE
            7'b0010011: cls = 4'd7;   // ITYPE
            7'b0110011: cls = 4'd8;   // RTYPE
            7'b0001111: cls = 4'd9;   // FENCE
            7'b1110011: cls = 4'd10;  // CSR
            default:    cls = 4'd15;
        endcase
        return cls;
    endfunction

    // Entry storage, kept free of reset so it can map onto RAM
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            empty;
    logic [XLEN-1:0] head_pc;
    logic [ILEN-1:0] head_instr;
    logic            req_live;
    logic            req_hit;
    logic            req_miss;
    logic            req_stall;
    logic            do_push;
    logic            do_pop;

    // Ready depends only on the registered count, so a pop in the same
    // cycle never opens a slot for a push
    assign in_ready   = (count < DEPTH_COUNT);
    assign occupancy  = count;
    assign empty      = (count == '0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    // Flush suppresses every fetch outcome and the incoming entry
    assign req_live  = fetch_req && !flush;
    assign req_hit   = req_live && !empty && (head_pc == fetch_pc);
    assign req_miss  = req_live && !empty && (head_pc != fetch_pc);
    assign req_stall = req_live && empty;
    assign do_push   = in_valid && in_ready && !flush;
    assign do_pop    = req_hit;

    // Pointer and occupancy bookkeeping; flush returns the queue to empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Write the offered entry into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // Registered fetch response; instr/opclass hold when nothing is delivered
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_instr   <= '0;
            rsp_opclass <= '0;
        end else if (req_hit) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b0;
            rsp_instr   <= head_instr;
            rsp_opclass <= decode_opclass(head_instr[6:0]);
        end else if (req_miss) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_instr   <= NOP_INSTR;
            rsp_opclass <= OPC_ITYPE;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
        end
    end

    // Saturating stall and mismatch counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            mismatch_cnt <= '0;
        end else begin
            if (req_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (req_miss && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_ifetch_queue.sv
// tb/tb_riscv_ifetch_queue.sv - scoreboard bench for riscv_ifetch_queue
module tb_riscv_ifetch_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic [3:0]  rsp_opclass;
    logic [3:0]  occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] mismatch_cnt;

    riscv_ifetch_queue #(
        .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
        .rsp_opclass(rsp_opclass), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .mismatch_cnt(mismatch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        bit          valid;
        bit          err;
        logic [31:0] instr;
        logic [3:0]  opc;
        int          occ;
        int          stall;
        int          mism;
        bit          rdy;
    } exp_t;

    // Reference model state
    ent_t        mq[$];
    exp_t        exp_q[$];
    int          m_stall;
    int          m_mism;
    logic [31:0] m_instr;
    logic [3:0]  m_opc;

    int checks   = 0;
    int failures = 0;

    logic [6:0] opc_tab [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                 7'b0110011, 7'b0001111, 7'b1110011};

    function automatic logic [3:0] ref_class(input logic [31:0] ins);
        logic [3:0] r;
        r = 4'd15;
        for (int i = 0; i < 11; i++) begin
            if (ins[6:0] == opc_tab[i]) r = 4'(i);
        end
        return r;
    endfunction

    // One cycle of the queue as described by its rules, producing the
    // response and state expected after the next clock edge
    task automatic model_step(input bit rst, input bit iv, input logic [31:0] ipc,
                              input logic [31:0] iins, input bit freq,
                              input logic [31:0] fpc, input bit fl);
        exp_t e;
        bit   room;
        e.valid = 0;
        e.err   = 0;
        if (rst) begin
            mq.delete();
            m_stall = 0;
            m_mism  = 0;
            m_instr = 0;
            m_opc   = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            room = (mq.size() < DEPTH);
            if (freq) begin
                if (mq.size() == 0) begin
                    if (m_stall < SAT) m_stall++;
                end else if (mq[0].pc == fpc) begin
                    e.valid = 1;
                    m_instr = mq[0].instr;
                    m_opc   = ref_class(m_instr);
                    void'(mq.pop_front());
                end else begin
                    e.valid = 1;
                    e.err   = 1;
                    m_instr = 32'h0000_0013;
                    m_opc   = 4'd7;
                    if (m_mism < SAT) m_mism++;
                end
            end
            if (iv && room) mq.push_back('{pc: ipc, instr: iins});
        end
        e.instr = m_instr;
        e.opc   = m_opc;
        e.occ   = mq.size();
        e.stall = m_stall;
        e.mism  = m_mism;
        e.rdy   = (mq.size() < DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit iv, input logic [31:0] ipc,
                        input logic [31:0] iins, input bit freq,
                        input logic [31:0] fpc, input bit fl);
        reset     = rst;
        in_valid  = iv;
        in_pc     = ipc;
        in_instr  = iins;
        fetch_req = freq;
        fetch_pc  = fpc;
        flush     = fl;
        model_step(rst, iv, ipc, iins, freq, fpc, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] head_pc_or(input logic [31:0] dflt);
        return (mq.size() != 0) ? mq[0].pc : dflt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expectation per clock, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e.valid));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_instr", rsp_instr, e.instr);
            chk("rsp_opclass", 32'(rsp_opclass), 32'(e.opc));
            chk("occupancy", 32'(occupancy), 32'(e.occ));
            chk("in_ready", 32'(in_ready), 32'(e.rdy));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
            chk("mismatch_cnt", 32'(mismatch_cnt), 32'(e.mism));
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 12);
        if (k < 11) r[6:0] = opc_tab[k];
        return r;
    endfunction

    initial begin
        logic [31:0] pc;
        logic [31:0] fpc;
        bit          iv;
        bit          fr;
        bit          fl;

        // Reset, then fill the queue and offer a ninth entry
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 32'(i * 4), 32'h0050_0093, 0, 0, 0);
        idle();

        // In-order delivery from the full queue
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 32'(i * 4), 0);
        idle();

        // Flush, then mismatch followed by a correct re-request
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 32'h100, 32'h0000_0033, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h104, 0);
        step(0, 0, 0, 0, 1, 32'h100, 0);
        idle();

        // Empty stall with a same-cycle push: no bypass
        step(0, 1, 32'h0, 32'h0000_00B7, 1, 32'h0, 0);
        step(0, 0, 0, 0, 1, 32'h0, 0);
        idle();

        // Flush wins over push and a matching fetch
        for (int i = 0; i < 3; i++) step(0, 1, 32'h200 + 32'(i * 4), rand_instr(), 0, 0, 0);
        step(0, 1, 32'h300, rand_instr(), 1, 32'h200, 1);
        step(0, 1, 32'h400, rand_instr(), 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h400, 0);

        // 40 push/pop pairs across the pointer wrap
        step(0, 1, 32'h1000, rand_instr(), 0, 0, 0);
        for (int i = 1; i <= 40; i++)
            step(0, 1, 32'h1000 + 32'(i * 4), rand_instr(), 1, head_pc_or(0), 0);
        step(0, 0, 0, 0, 1, head_pc_or(0), 0);

        // Empty requests drive the stall counter into saturation
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 32'h0, 0);

        // Reset in the middle of traffic
        for (int i = 0; i < 4; i++) step(0, 1, 32'h2000 + 32'(i * 4), rand_instr(), 1, 32'h1, 0);
        step(1, 1, 32'h3000, rand_instr(), 1, head_pc_or(0), 0);
        idle();

        // Randomized traffic
        pc = 32'h8000;
        for (int i = 0; i < 3000; i++) begin
            iv = ($urandom_range(0, 99) < 60);
            fr = ($urandom_range(0, 99) < 55);
            fl = ($urandom_range(0, 99) < 3);
            if (mq.size() != 0 && $urandom_range(0, 3) != 0) fpc = mq[0].pc;
            else fpc = {$urandom_range(0, 16383), 2'b00};
            step(($urandom_range(0, 999) < 3), iv, pc, rand_instr(), fr, fpc, fl);
            pc = pc + 32'd4;
        end
        idle();
        idle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_ifetch_queue.md
Name: riscv_ifetch_queue

Overview:
Parametrised instruction-feed queue between the UVM instruction driver and the RISC-V core fetch port. It replaces the single-cycle instr/pc pin exchange with a DEPTH-entry buffer of {pc, instr} pairs. The core requests by PC and receives a registered response. The block checks the PC against the queue head, supports a redirect flush, decodes the opcode class of each delivered instruction, and keeps saturating stall and mismatch counters.

Parameters:
XLEN, 32, PC width
ILEN, 32, instruction width (>=7)
DEPTH, 8, queue entries; power of 2, >=2
CNT_W, 16, width of stall/mismatch counters

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high
in_valid  input  1  driver offers an entry
in_ready  output  1  queue can accept (count < DEPTH)
in_pc  input  XLEN  PC of offered instruction
in_instr  input  ILEN  offered instruction
fetch_req  input  1  core fetch request this cycle
fetch_pc  input  XLEN  PC the core is fetching
flush  input  1  redirect; discard all queued entries
rsp_valid  output  1  registered response valid
rsp_instr  output  ILEN  delivered instruction
rsp_err  output  1  PC mismatch on this response
rsp_opclass  output  4  opcode class of rsp_instr
occupancy  output  $clog2(DEPTH)+1  entries held
stall_cnt  output  CNT_W  requests that found the queue empty
mismatch_cnt  output  CNT_W  requests with a head PC mismatch

Behaviour:
- Reset (sync, active-high) clears pointers, occupancy, counters and all registered outputs to 0. in_ready reads 1 the cycle after reset deasserts. Reset overrides flush, push and pop.
- Push: occurs when in_valid && in_ready. in_ready = (occupancy < DEPTH) and is derived only from the registered occupancy, so a same-cycle pop never frees a slot for a push. Entries are stored in order. The write pointer wraps modulo DEPTH.
- Fetch, evaluated on cycles with fetch_req=1 and flush=0, from state at the start of the cycle (no push-to-pop bypass). Each outcome is registered and visible one cycle after the request:
  - Non-empty and head.pc == fetch_pc: pop the head. rsp_valid=1, rsp_instr=head.instr, rsp_err=0.
  - Non-empty and PC differs: no pop. rsp_valid=1, rsp_instr=32'h00000013 (NOP, zero-extended/truncated to ILEN), rsp_err=1, mismatch_cnt+1.
  - Empty: rsp_valid=0, rsp_err=0, rsp_instr holds its previous value, stall_cnt+1.
- fetch_req=0: next rsp_valid=0 and rsp_err=0. rsp_instr and rsp_opclass hold.
- Simultaneous push and pop: both take effect, occupancy unchanged. When the queue is full, in_ready=0, so only the pop occurs.
- Flush: takes priority over push and pop in the same cycle. Pointers and occupancy become 0 next cycle, the offered entry is dropped, next rsp_valid=0, counters are unchanged, and the fetch is not counted.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- rsp_opclass is registered alongside rsp_instr and decoded from instr[6:0]:
  - 0 LUI 0110111; 1 AUIPC 0010111; 2 JAL 1101111; 3 JALR 1100111
  - 4 BRANCH 1100011; 5 LOAD 0000011; 6 STORE 0100011; 7 ITYPE 0010011
  - 8 RTYPE 0110011; 9 FENCE 0001111; 10 CSR 1110011; 15 any other value
  - On a mismatch response the value is 7 (NOP).
- occupancy is always the registered count in 0..DEPTH.

Test Plan:
- Reset then fill: push 8 entries (pc 0x0..0x1C step 4, instr 0x00500093) -> occupancy=8, in_ready=0 in the cycle after the 8th push, 9th offer not accepted.
- In-order delivery: from the full queue, fetch_req with fetch_pc 0x0, 0x4, 0x8 on consecutive cycles -> rsp_valid=1 on each following cycle, rsp_instr=0x00500093, rsp_opclass=7, rsp_err=0, occupancy drops 8->5.
- Mismatch: head pc 0x100, fetch_pc 0x104 -> rsp_valid=1, rsp_err=1, rsp_instr=0x00000013, mismatch_cnt=1, occupancy unchanged. Re-request 0x100 -> delivered normally.
- Empty stall and no bypass: empty queue, same cycle push(pc 0x0, instr 0x000000B7) and fetch_req pc 0x0 -> rsp_valid=0, stall_cnt=1. Next request -> rsp_valid=1, rsp_opclass=0 (LUI).
- Flush priority: occupancy 3, same cycle flush+push+fetch_req matching head -> next cycle occupancy=0, rsp_valid=0, counters unchanged. Following push accepted, occupancy=1.
- Wrap and saturation: with CNT_W=4, perform 40 push/pop pairs across the pointer wrap -> all delivered in order. Then 20 empty requests -> stall_cnt holds 15. Assert reset mid-stream -> all outputs 0 next cycle.
